// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int FETCH_Q_DEPTH = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Redirect targets are word addresses; the low byte-offset bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control, instruction-memory and decode-side signals of the fetch sequencer.
interface fetch_ctrl_if;

    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    modport master (
        input  fetch_en,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        input  out_ready,
        output imem_addr,
        output imem_req,
        output out_valid,
        output out_pc,
        output out_inst
    );

    modport slave (
        output fetch_en,
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        output out_ready,
        input  imem_addr,
        input  imem_req,
        input  out_valid,
        input  out_pc,
        input  out_inst
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding returned {pc, inst} words; flush beats push/pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [FETCH_Q_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, tracks the single 1-cycle memory read and
// buffers returns in a 2-entry queue. Optional counters under FETCH_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;

    logic         vld_p1;
    logic [31:0]  pc_p1;

    logic         issue;
    logic         pop;
    logic         push;
    logic         q_pop;
    logic         flush;
    logic [1:0]   q_count;
    logic [2:0]   occ;
    fetch_entry_t q_head;
    fetch_entry_t ret_entry;

    logic         sel_valid;
    logic [31:0]  sel_pc;
    logic [31:0]  sel_inst;
    logic         out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= BOOT;
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            vld_p1 <= issue;
        end
    end

    // Issue stage -> return stage: remember which PC the outstanding read belongs to.
    always_ff @(posedge clk) begin
        if (issue) pc_p1 <= pc;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        issue          = 1'b0;
        push           = 1'b0;
        q_pop          = 1'b0;
        flush          = 1'b0;
        sel_valid      = 1'b0;
        sel_pc         = 32'd0;
        sel_inst       = 32'd0;
        ret_entry.pc   = pc_p1;
        ret_entry.inst = bus.imem_rdata;
        occ            = {1'b0, q_count} + {2'b00, vld_p1};

        // Buffered words are older than the one returning now, so they go first.
        if (q_count != 2'd0) begin
            sel_valid = 1'b1;
            sel_pc    = q_head.pc;
            sel_inst  = q_head.inst;
        end else if (vld_p1) begin
            sel_valid = 1'b1;
            sel_pc    = pc_p1;
            sel_inst  = bus.imem_rdata;
        end

        out_valid = sel_valid && !bus.redirect_valid;
        pop       = out_valid && bus.out_ready;

        if (bus.redirect_valid) begin
            flush  = 1'b1;
            pc_nxt = word_align(bus.redirect_pc);
        end else begin
            q_pop = pop && (q_count != 2'd0);
            push  = vld_p1 && !(pop && (q_count == 2'd0));
            // Only issue when the word is guaranteed a queue slot on return.
            if ((state == RUN) && (occ < (3'(FETCH_Q_DEPTH) + {2'b00, pop}))) begin
                issue  = 1'b1;
                pc_nxt = pc + 32'd4;
            end
        end

        case (state)
            BOOT:    state_nxt = bus.fetch_en ? RUN : HALT;
            RUN:     if (!bus.fetch_en) state_nxt = HALT;
            HALT:    if (bus.fetch_en) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    fetch_queue u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ret_entry),
        .pop       (q_pop),
        .flush     (flush),
        .head      (q_head),
        .count     (q_count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = sel_pc;
    assign bus.out_inst  = sel_inst;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (out_valid && !bus.out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a queue-level model of outstanding fetches
// plus directed scenarios with literal expectations.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: every fetched-but-undelivered PC in program order, in flight or buffered.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    int          m_state;
    int          m_fetch;
    int          m_stall;

    logic        prev_req;
    logic [31:0] prev_addr;
    logic        s_valid;
    logic        s_req;
    logic [31:0] s_pc;
    logic [31:0] s_addr;
    logic [31:0] s_fetch;
    logic [31:0] s_stall;
    logic [31:0] stall_pc;
    logic [15:0] rdy_pat;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic exp_valid;
        logic exp_pop;
        logic exp_issue;
        @(negedge clk);
        rst                = 1'b1;
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        bus.imem_rdata     = prev_req ? memfn(prev_addr) : 32'hDEAD_BEEF;
        #1;
        exp_valid = (m_q.size() > 0) && !rv;
        exp_pop   = exp_valid && rdy;
        exp_issue = (m_state == M_RUN) && !rv && ((m_q.size() - (exp_pop ? 1 : 0)) < 2);
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_issue});
        if (exp_issue) check("imem_addr", bus.imem_addr, m_pc);
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("out_pc", bus.out_pc, m_q[0]);
            check("out_inst", bus.out_inst, memfn(m_q[0]));
        end
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check("perf_stall_cnt", perf_stall_cnt, m_stall);
        s_fetch = perf_fetch_cnt;
        s_stall = perf_stall_cnt;
`endif
        s_valid   = bus.out_valid;
        s_req     = bus.imem_req;
        s_pc      = bus.out_pc;
        s_addr    = bus.imem_addr;
        prev_req  = bus.imem_req;
        prev_addr = bus.imem_addr;
        if (exp_pop) m_fetch++;
        if (exp_valid && !rdy) m_stall++;
        if (rv) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (exp_issue) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        m_state = fe ? M_RUN : M_HALT;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, RST_PC);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_inst", bus.out_inst, 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        m_q.delete();
        m_pc     = RST_PC;
        m_state  = M_BOOT;
        m_fetch  = 0;
        m_stall  = 0;
        prev_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.out_ready      = 1'b0;
        bus.imem_rdata     = 32'd0;
        prev_req           = 1'b0;
        prev_addr          = 32'd0;
        bus.fetch_en       = 1'b1;
        do_reset();

        // Power-up streaming: boot cycle, issue of 0x0, then one word per cycle.
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("first_issue_req", {31'd0, s_req}, 32'd1);
        check("first_issue_addr", s_addr, 32'h0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("first_out_valid", {31'd0, s_valid}, 32'd1);
        check("first_out_pc", s_pc, 32'h0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("second_out_pc", s_pc, 32'h4);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Decode backpressure for five cycles.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            if (i == 0) begin
                stall_pc = s_pc;
                check("stall_head_pc", s_pc, 32'h18);
            end else begin
                check("stall_hold_pc", s_pc, stall_pc);
            end
        end
        check("stall_no_issue", {31'd0, s_req}, 32'd0);
        repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect with the queue full.
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b1);
        check("redir_valid_R", {31'd0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("redir_valid_R1", {31'd0, s_valid}, 32'd0);
        check("redir_issue_R1", s_addr, 32'h100);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("redir_pc_R2", s_pc, 32'h100);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Misaligned redirect target.
        step(1'b1, 1'b1, 32'h102, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("misalign_pc", s_pc, 32'h100);
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);

        // fetch_en low for three cycles, then resume.
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1);
        check("drain_valid", {31'd0, s_valid}, 32'd0);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect while halted.
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("halt_redir_pc", s_pc, 32'h200);
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);

        // PC wrap at 2^32.
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);
        check("wrap_pc", s_pc, 32'h0);
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Irregular decode-ready pattern.
        rdy_pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'd0, rdy_pat[i]);

        // Reset with a full queue, then restart from RESET_PC.
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        check("restart_req", {31'd0, s_req}, 32'd1);
        check("restart_addr", s_addr, RST_PC);

        // Ten handshakes and four stall cycles since reset.
        repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
`ifdef FETCH_PERF_EN
        check("perf_fetch_10", s_fetch, 32'd10);
        check("perf_stall_4", s_stall, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
